// File: rtl/dc_bsp_pkg.sv
// rtl/dc_bsp_pkg.sv - shared types and constants for the AVMM page-boundary splitter
package dc_bsp_pkg;

  localparam int HOST_PAGE_WORDS = 64;
  localparam int BSP_ADDR_W      = 48;
  localparam int BSP_DATA_W      = 512;
  localparam int BSP_BC_W        = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_SECOND
  } boundary_split_st_e;

  // Contents of the single registered output stage toward the sink.
  typedef struct packed {
    logic                      read;
    logic                      write;
    logic [BSP_ADDR_W-1:0]     address;
    logic [BSP_BC_W-1:0]       burstcount;
    logic [BSP_DATA_W/8-1:0]   byteenable;
    logic [BSP_DATA_W-1:0]     writedata;
  } avmm_split_cmd_t;

endpackage

// File: rtl/avmm_page_boundary_split.sv
// rtl/avmm_page_boundary_split.sv - splits AVMM bursts that cross a BOUNDARY_WORDS-aligned boundary
// Optional split counter output enabled by AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN.
module avmm_page_boundary_split
  import dc_bsp_pkg::*;
#(
  parameter int ADDR_WIDTH       = BSP_ADDR_W,
  parameter int DATA_WIDTH       = BSP_DATA_W,
  parameter int BURSTCOUNT_WIDTH = BSP_BC_W,
  parameter int BOUNDARY_WORDS   = HOST_PAGE_WORDS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       src_address,
  input  logic [BURSTCOUNT_WIDTH-1:0] src_burstcount,
  input  logic                        src_read,
  input  logic                        src_write,
  input  logic [DATA_WIDTH-1:0]       src_writedata,
  input  logic [DATA_WIDTH/8-1:0]     src_byteenable,
  output logic                        src_waitrequest,
  output logic [DATA_WIDTH-1:0]       src_readdata,
  output logic                        src_readdatavalid,
  output logic [ADDR_WIDTH-1:0]       snk_address,
  output logic [BURSTCOUNT_WIDTH-1:0] snk_burstcount,
  output logic                        snk_read,
  output logic                        snk_write,
  output logic [DATA_WIDTH-1:0]       snk_writedata,
  output logic [DATA_WIDTH/8-1:0]     snk_byteenable,
  input  logic                        snk_waitrequest,
  input  logic [DATA_WIDTH-1:0]       snk_readdata,
  input  logic                        snk_readdatavalid
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
  ,
  output logic [31:0]                 split_cnt
`endif
);

  localparam int BW_LOG2 = $clog2(BOUNDARY_WORDS);
  localparam int BC      = BURSTCOUNT_WIDTH;
  localparam logic [BC-1:0] BC_ONE = BC'(1);

  // Length of the first sub-burst: whatever fits before the next boundary.
  function automatic logic [BC-1:0] first_len_f(input logic [BW_LOG2-1:0] offs,
                                                input logic [BC-1:0]      bc);
    logic [BW_LOG2:0] to_bnd;
    logic [BW_LOG2:0] bc_ext;
    to_bnd = (BW_LOG2+1)'(BOUNDARY_WORDS) - {1'b0, offs};
    bc_ext = (BW_LOG2+1)'(bc);
    return (bc_ext <= to_bnd) ? bc : BC'(to_bnd);
  endfunction

  boundary_split_st_e      state_q;
  avmm_split_cmd_t         out_q;
  logic                    out_valid_q;
  logic [BC-1:0]           sub_left_q;
  logic [BC-1:0]           rest_q;
  logic [ADDR_WIDTH-1:0]   next_addr_q;

  logic                    load_ok;
  logic                    accept;
  logic [BC-1:0]           first_len;
  logic [BC-1:0]           rest_len;
  logic                    is_split;

  assign src_waitrequest = reset | (out_valid_q & snk_waitrequest) | (state_q == ST_RD_SECOND);
  assign load_ok         = !out_valid_q || !snk_waitrequest;
  assign accept          = (src_read | src_write) & !src_waitrequest;
  assign first_len       = first_len_f(src_address[BW_LOG2-1:0], src_burstcount);
  assign rest_len        = src_burstcount - first_len;
  assign is_split        = (rest_len != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sub_left_q  <= '0;
      rest_q      <= '0;
      next_addr_q <= '0;
    end else begin
      // A consumed or empty slot drops its command unless refilled below.
      if (load_ok) begin
        out_valid_q <= 1'b0;
        out_q.read  <= 1'b0;
        out_q.write <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            out_valid_q      <= 1'b1;
            out_q.address    <= src_address;
            out_q.burstcount <= first_len;
            out_q.byteenable <= src_byteenable;
            out_q.writedata  <= src_writedata;
            next_addr_q      <= src_address + ADDR_WIDTH'(first_len);
            rest_q           <= rest_len;
            if (src_write) begin
              out_q.write <= 1'b1;
              out_q.read  <= 1'b0;
              sub_left_q  <= first_len - BC_ONE;
              if (src_burstcount > BC_ONE) state_q <= ST_WR_BURST;
            end else begin
              out_q.read  <= 1'b1;
              out_q.write <= 1'b0;
              sub_left_q  <= '0;
              if (is_split) state_q <= ST_RD_SECOND;
            end
          end
        end
        ST_WR_BURST: begin
          if (src_write && !src_waitrequest) begin
            out_valid_q      <= 1'b1;
            out_q.write      <= 1'b1;
            out_q.read       <= 1'b0;
            out_q.byteenable <= src_byteenable;
            out_q.writedata  <= src_writedata;
            if (sub_left_q == '0) begin
              out_q.address    <= next_addr_q;
              out_q.burstcount <= rest_q;
              sub_left_q       <= rest_q - BC_ONE;
              rest_q           <= '0;
              if (rest_q <= BC_ONE) state_q <= ST_IDLE;
            end else begin
              sub_left_q <= sub_left_q - BC_ONE;
              if (sub_left_q == BC_ONE && rest_q == '0) state_q <= ST_IDLE;
            end
          end
        end
        ST_RD_SECOND: begin
          if (load_ok) begin
            out_valid_q      <= 1'b1;
            out_q.read       <= 1'b1;
            out_q.write      <= 1'b0;
            out_q.address    <= next_addr_q;
            out_q.burstcount <= rest_q;
            rest_q           <= '0;
            state_q          <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
  logic [31:0] split_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      split_cnt_q <= '0;
    end else if (state_q == ST_IDLE && accept && is_split && split_cnt_q != 32'hFFFF_FFFF) begin
      split_cnt_q <= split_cnt_q + 32'd1;
    end
  end

  assign split_cnt = split_cnt_q;
`endif

  assign snk_address       = out_q.address;
  assign snk_burstcount    = out_q.burstcount;
  assign snk_read          = out_q.read;
  assign snk_write         = out_q.write;
  assign snk_writedata     = out_q.writedata;
  assign snk_byteenable    = out_q.byteenable;
  assign src_readdata      = snk_readdata;
  assign src_readdatavalid = snk_readdatavalid;

endmodule

// File: tb/tb_avmm_page_boundary_split.sv
// tb/tb_avmm_page_boundary_split.sv - self-checking bench for avmm_page_boundary_split
module tb_avmm_page_boundary_split;

  localparam int AW  = 48;
  localparam int DW  = 512;
  localparam int BW  = 5;
  localparam int BEW = DW / 8;
  localparam int PAGE = 64;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   src_address;
  logic [BW-1:0]   src_burstcount;
  logic            src_read;
  logic            src_write;
  logic [DW-1:0]   src_writedata;
  logic [BEW-1:0]  src_byteenable;
  logic            src_waitrequest;
  logic [DW-1:0]   src_readdata;
  logic            src_readdatavalid;
  logic [AW-1:0]   snk_address;
  logic [BW-1:0]   snk_burstcount;
  logic            snk_read;
  logic            snk_write;
  logic [DW-1:0]   snk_writedata;
  logic [BEW-1:0]  snk_byteenable;
  logic            snk_waitrequest;
  logic [DW-1:0]   snk_readdata;
  logic            snk_readdatavalid;
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
  logic [31:0]     split_cnt;
`endif

  avmm_page_boundary_split dut (
    .clk               (clk),
    .reset             (reset),
    .src_address       (src_address),
    .src_burstcount    (src_burstcount),
    .src_read          (src_read),
    .src_write         (src_write),
    .src_writedata     (src_writedata),
    .src_byteenable    (src_byteenable),
    .src_waitrequest   (src_waitrequest),
    .src_readdata      (src_readdata),
    .src_readdatavalid (src_readdatavalid),
    .snk_address       (snk_address),
    .snk_burstcount    (snk_burstcount),
    .snk_read          (snk_read),
    .snk_write         (snk_write),
    .snk_writedata     (snk_writedata),
    .snk_byteenable    (snk_byteenable),
    .snk_waitrequest   (snk_waitrequest),
    .snk_readdata      (snk_readdata),
    .snk_readdatavalid (snk_readdatavalid)
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
    ,
    .split_cnt         (split_cnt)
`endif
  );

  typedef struct packed {
    logic           rd;
    logic           wr;
    logic [AW-1:0]  addr;
    logic [BW-1:0]  bc;
    logic [BEW-1:0] be;
    logic [DW-1:0]  data;
  } beat_t;

  beat_t          obs_q[$];
  beat_t          exp_q[$];
  int             obs_cyc[$];
  logic [DW-1:0]  wdata[16];
  logic [BEW-1:0] wbe[16];
  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  int             exp_splits = 0;
  bit             bp_rand = 0;
  bit             bp_force = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    snk_waitrequest = bp_rand ? ($urandom_range(0, 2) == 0) : bp_force;
  end

  // Sink-side monitor: records every beat the sink actually takes.
  always @(negedge clk) begin
    beat_t e;
    if (!reset && (snk_read || snk_write) && !snk_waitrequest) begin
      e = '0;
      e.rd = snk_read;
      e.wr = snk_write;
      e.addr = snk_address;
      e.bc = snk_burstcount;
      if (snk_write) begin
        e.be = snk_byteenable;
        e.data = snk_writedata;
      end
      obs_q.push_back(e);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Reference: a burst is cut where it would run past the next page boundary.
  task automatic model_cmd(input bit is_wr, input logic [AW-1:0] a, input int bc);
    int    words_left;
    int    first;
    beat_t e;
    words_left = PAGE - int'(a % PAGE);
    first = (bc <= words_left) ? bc : words_left;
    if (first < bc) exp_splits++;
    if (is_wr) begin
      for (int i = 0; i < bc; i++) begin
        e = '0;
        e.wr = 1'b1;
        e.addr = (i < first) ? a : a + AW'(first);
        e.bc = (i < first) ? BW'(first) : BW'(bc - first);
        e.be = wbe[i];
        e.data = wdata[i];
        exp_q.push_back(e);
      end
    end else begin
      e = '0;
      e.rd = 1'b1;
      e.addr = a;
      e.bc = BW'(first);
      exp_q.push_back(e);
      if (first < bc) begin
        e.addr = a + AW'(first);
        e.bc = BW'(bc - first);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < DW / 32; j++) wdata[i][j*32 +: 32] = $urandom;
      wbe[i] = {$urandom, $urandom};
    end
  endtask

  task automatic clear_q();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic send_cmd(input bit is_wr, input logic [AW-1:0] a, input int bc, input int nbeats);
    int t;
    int nb;
    nb = is_wr ? nbeats : 1;
    for (int i = 0; i < nb; i++) begin
      src_address = a;
      src_burstcount = BW'(bc);
      src_write = is_wr;
      src_read = !is_wr;
      src_writedata = wdata[i];
      src_byteenable = wbe[i];
      t = 0;
      @(negedge clk);
      while (src_waitrequest && t < 200) begin
        t++;
        @(negedge clk);
      end
      if (t >= 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout beat %0d got waitrequest=1 want 0", i);
      end
      @(posedge clk);
      #1;
    end
    src_write = 1'b0;
    src_read = 1'b0;
  endtask

  task automatic drain();
    bp_rand = 0;
    bp_force = 0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    src_read = 0; src_write = 0; src_address = '0; src_burstcount = '0;
    src_writedata = '0; src_byteenable = '0; snk_readdata = '0; snk_readdatavalid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (src_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitreq got %b want 1", src_waitrequest); end
    total++;
    if ({snk_read, snk_write} !== 2'b00) begin bad++; $display("FAIL reset_rdwr got %b want 00", {snk_read, snk_write}); end
    total++;
    if (snk_address !== '0 || snk_burstcount !== '0) begin
      bad++; $display("FAIL reset_addr_bc got a=%h bc=%0d want 0 0", snk_address, snk_burstcount);
    end
    total++;
    if (snk_writedata !== '0 || snk_byteenable !== '0) begin bad++; $display("FAIL reset_data got nonzero want 0"); end
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
    total++;
    if (split_cnt !== 32'd0) begin bad++; $display("FAIL reset_split_cnt got %0d want 0", split_cnt); end
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_split();
    clear_q();
    for (int i = 0; i < 16; i++) begin
      wdata[i] = {16{32'(32'hD000_0000 + i)}};
      wbe[i] = '1;
    end
    model_cmd(1, 48'h3C, 16);
    send_cmd(1, 48'h3C, 16, 16);
    drain();
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL wsplit_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL wsplit beat %0d got a=%h bc=%0d d=%h want a=%h bc=%0d d=%h", i,
                 obs_q[i].addr, obs_q[i].bc, obs_q[i].data[31:0], exp_q[i].addr, exp_q[i].bc, exp_q[i].data[31:0]);
      end
    end
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
    total++;
    if (split_cnt !== 32'(exp_splits)) begin bad++; $display("FAIL wsplit_cnt got %0d want %0d", split_cnt, exp_splits); end
`endif
  endtask

  task automatic test_read_split();
    int n;
    logic [DW-1:0] rd;
    clear_q();
    model_cmd(0, 48'h7E, 8);
    send_cmd(0, 48'h7E, 8, 1);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (src_waitrequest) n++;
    end
    total++;
    if (n != 1) begin bad++; $display("FAIL rsplit_wait_cycles got %0d want 1", n); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < DW / 32; j++) rd[j*32 +: 32] = $urandom;
      snk_readdata = rd;
      snk_readdatavalid = 1'b1;
      #1;
      total++;
      if (src_readdatavalid !== 1'b1 || src_readdata !== rd) begin
        bad++; $display("FAIL rdata_pass beat %0d got v=%b d=%h want v=1 d=%h", i, src_readdatavalid, src_readdata[31:0], rd[31:0]);
      end
      @(posedge clk);
      #1;
    end
    snk_readdatavalid = 1'b0;
    drain();
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rsplit_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rsplit cmd %0d got rd=%b a=%h bc=%0d want rd=%b a=%h bc=%0d", i,
                 obs_q[i].rd, obs_q[i].addr, obs_q[i].bc, exp_q[i].rd, exp_q[i].addr, exp_q[i].bc);
      end
    end
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
    total++;
    if (split_cnt !== 32'(exp_splits)) begin bad++; $display("FAIL rsplit_cnt got %0d want %0d", split_cnt, exp_splits); end
`endif
  endtask

  task automatic test_no_split();
    clear_q();
    fill_random();
    model_cmd(1, 48'h30, 16);
    send_cmd(1, 48'h30, 16, 16);
    drain();
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL nosplit_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL nosplit beat %0d got a=%h bc=%0d d=%h want a=%h bc=%0d d=%h", i,
                 obs_q[i].addr, obs_q[i].bc, obs_q[i].data[31:0], exp_q[i].addr, exp_q[i].bc, exp_q[i].data[31:0]);
      end
    end
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
    total++;
    if (split_cnt !== 32'(exp_splits)) begin bad++; $display("FAIL nosplit_cnt got %0d want %0d", split_cnt, exp_splits); end
`endif
  endtask

  task automatic test_backpressure();
    beat_t snap;
    beat_t cur;
    clear_q();
    fill_random();
    model_cmd(1, 48'h3C, 16);
    fork
      send_cmd(1, 48'h3C, 16, 16);
      begin
        int t;
        t = 0;
        while (obs_q.size() < 6 && t < 200) begin
          @(posedge clk);
          t++;
        end
        @(negedge clk);
        bp_force = 1;
        @(negedge clk);
        snap = {snk_read, snk_write, snk_address, snk_burstcount, snk_byteenable, snk_writedata};
        total++;
        if (snap.wr !== 1'b1 || src_waitrequest !== 1'b1) begin
          bad++; $display("FAIL bp_stall_start got wr=%b waitreq=%b want 1 1", snap.wr, src_waitrequest);
        end
        repeat (4) begin
          @(negedge clk);
          cur = {snk_read, snk_write, snk_address, snk_burstcount, snk_byteenable, snk_writedata};
          total++;
          if (cur !== snap || src_waitrequest !== 1'b1) begin
            bad++; $display("FAIL bp_hold got a=%h bc=%0d d=%h wreq=%b want a=%h bc=%0d d=%h wreq=1",
                            cur.addr, cur.bc, cur.data[31:0], src_waitrequest, snap.addr, snap.bc, snap.data[31:0]);
          end
        end
        bp_force = 0;
      end
    join
    drain();
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp beat %0d got a=%h bc=%0d d=%h want a=%h bc=%0d d=%h", i,
                 obs_q[i].addr, obs_q[i].bc, obs_q[i].data[31:0], exp_q[i].addr, exp_q[i].bc, exp_q[i].data[31:0]);
      end
    end
  endtask

  task automatic test_singletons();
    int splits_before;
    splits_before = exp_splits;
    clear_q();
    fill_random();
    wbe[0] = 64'h0F0F_0F0F_0F0F_0F0F;
    model_cmd(1, 48'h3F, 1);
    send_cmd(1, 48'h3F, 1, 1);
    for (int j = 0; j < DW / 32; j++) wdata[0][j*32 +: 32] = $urandom;
    wbe[0] = 64'hF0F0_0000_FFFF_0001;
    model_cmd(1, 48'h40, 1);
    send_cmd(1, 48'h40, 1, 1);
    drain();
    total++;
    if (obs_q.size() != 2) begin bad++; $display("FAIL single_count got %0d want 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL single beat %0d got a=%h bc=%0d be=%h want a=%h bc=%0d be=%h", i,
                 obs_q[i].addr, obs_q[i].bc, obs_q[i].be, exp_q[i].addr, exp_q[i].bc, exp_q[i].be);
      end
    end
    if (obs_cyc.size() >= 2) begin
      total++;
      if (obs_cyc[1] - obs_cyc[0] != 1) begin
        bad++; $display("FAIL single_rate got gap=%0d want 1", obs_cyc[1] - obs_cyc[0]);
      end
    end
    total++;
    if (exp_splits != splits_before) begin bad++; $display("FAIL single_model_splits got %0d want %0d", exp_splits, splits_before); end
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
    total++;
    if (split_cnt !== 32'(splits_before)) begin bad++; $display("FAIL single_cnt got %0d want %0d", split_cnt, splits_before); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    clear_q();
    fill_random();
    send_cmd(1, 48'h100, 16, 6);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (src_waitrequest !== 1'b1) begin bad++; $display("FAIL midrst_waitreq got %b want 1", src_waitrequest); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({snk_write, snk_read} !== 2'b00) begin bad++; $display("FAIL midrst_idle got wr/rd=%b want 00", {snk_write, snk_read}); end
    exp_splits = 0;
    @(posedge clk);
    #1;
    clear_q();
    model_cmd(0, 48'h10, 4);
    send_cmd(0, 48'h10, 4, 1);
    drain();
    total++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin bad++; $display("FAIL midrst_count got %0d want 1", obs_q.size()); end
    else begin
      total++;
      if (obs_q[0] !== exp_q[0]) begin
        bad++; $display("FAIL midrst_read got rd=%b a=%h bc=%0d want rd=1 a=%h bc=%0d", obs_q[0].rd, obs_q[0].addr, obs_q[0].bc, exp_q[0].addr, exp_q[0].bc);
      end
    end
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
    total++;
    if (split_cnt !== 32'd0) begin bad++; $display("FAIL midrst_cnt got %0d want 0", split_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    bit            is_wr;
    int            bc;
    clear_q();
    bp_rand = 1;
    for (int n = 0; n < 30; n++) begin
      fill_random();
      is_wr = 1'($urandom_range(0, 1));
      bc = $urandom_range(1, 16);
      a = AW'({$urandom, $urandom});
      case ($urandom_range(0, 3))
        0: a[5:0] = 6'($urandom_range(48, 63));
        1: a = 48'hFFFF_FFFF_FFF0 + AW'($urandom_range(0, 15));
        default: ;
      endcase
      model_cmd(is_wr, a, bc);
      send_cmd(is_wr, a, bc, bc);
    end
    drain();
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand beat %0d got rd=%b wr=%b a=%h bc=%0d d=%h want rd=%b wr=%b a=%h bc=%0d d=%h", i,
                 obs_q[i].rd, obs_q[i].wr, obs_q[i].addr, obs_q[i].bc, obs_q[i].data[31:0],
                 exp_q[i].rd, exp_q[i].wr, exp_q[i].addr, exp_q[i].bc, exp_q[i].data[31:0]);
      end
    end
`ifdef AVMM_PAGE_BOUNDARY_SPLIT_STATS_EN
    total++;
    if (split_cnt !== 32'(exp_splits)) begin bad++; $display("FAIL rand_cnt got %0d want %0d", split_cnt, exp_splits); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_split();
    test_read_split();
    test_no_split();
    test_backpressure();
    test_singletons();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
